// File: rtl/tinysat_host_if.sv
// Pin bundle between the host-side driver (master) and the tinysat solver (slave).
interface tinysat_host_if #(
  parameter int unsigned NVARS = 4
) ();
  logic [4:0]       sat_data;
  logic             sat_load;
  logic             sat_run;
  logic [NVARS-1:0] sat_x;
  logic             sat_sol;
  logic             sat_done;

  modport master (output sat_data, sat_load, sat_run, input sat_x, sat_sol, sat_done);
  modport slave  (input sat_data, sat_load, sat_run, output sat_x, sat_sol, sat_done);
endinterface

// File: rtl/tinysat_host.sv
// Buffers a CNF literal stream, serializes it to the tinysat solver, runs it with a
// timeout and re-checks the returned assignment against the buffered clauses.
module tinysat_host #(
  parameter int unsigned NVARS   = 4,
  parameter int unsigned DEPTH   = 32,
  parameter int unsigned TIMEOUT = 1023
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             wr_valid_i,
  input  logic [4:0]       wr_lit_i,
  output logic             wr_ready_o,
  input  logic             clr_i,
  input  logic             start_i,
  output logic             busy_o,
  output logic             err_o,
  output logic             result_valid_o,
  output logic             result_sat_o,
  output logic [NVARS-1:0] result_x_o,
  output logic             check_ok_o,
  output logic             timeout_o,
  tinysat_host_if.master   sat
);
  localparam int unsigned      CntW     = $clog2(DEPTH + 1);
  localparam int unsigned      AddrW    = $clog2(DEPTH);
  localparam int unsigned      TmrW     = $clog2(TIMEOUT + 1);
  localparam logic [CntW-1:0]  DepthC   = CntW'(DEPTH);
  localparam logic [TmrW-1:0]  TimeoutC = TmrW'(TIMEOUT);
  localparam logic [4:0]       NVarsC   = 5'(NVARS);

  typedef enum logic [1:0] {StIdle, StLoad, StRun, StCheck} state_e;
  state_e state_q, state_d;

  logic [4:0]       lit_mem_q [DEPTH];
  logic [CntW-1:0]  count_q, idx_q;
  logic [TmrW-1:0]  tmr_q;
  logic             err_q, res_valid_q, res_sat_q, check_ok_q, timeout_q;
  logic [NVARS-1:0] res_x_q;
  logic             acc_q, all_q;

  logic       in_idle, lit_valid, wr_fire, wr_bad, start_ok, last_idx, expired;
  logic [4:0] cur_lit, sat_data;
  logic       sat_load, sat_run;
  logic       cur_true, acc_nxt, all_nxt, all_fin;

  // -16 has no positive counterpart in 5 bits; its magnitude reads as 16.
  function automatic logic [4:0] lit_mag(input logic [4:0] lit);
    return lit[4] ? -lit : lit;
  endfunction

  assign in_idle   = (state_q == StIdle);
  assign lit_valid = (wr_lit_i != 5'b10000) && (lit_mag(wr_lit_i) <= NVarsC);
  assign wr_fire   = wr_valid_i && wr_ready_o && !clr_i && lit_valid;
  assign wr_bad    = wr_valid_i && wr_ready_o && !clr_i && !lit_valid;
  assign start_ok  = in_idle && start_i && !clr_i && (count_q != '0);
  assign last_idx  = (idx_q == count_q - CntW'(1));
  assign expired   = (tmr_q == TimeoutC);
  assign cur_lit   = lit_mem_q[idx_q[AddrW-1:0]];

  // Clause evaluation; an empty clause leaves acc at 0 and so counts as unsatisfied.
  always_comb begin
    cur_true = 1'b0;
    for (int unsigned k = 0; k < NVARS; k++) begin
      if (lit_mag(cur_lit) == 5'(k + 1)) cur_true = cur_lit[4] ? !res_x_q[k] : res_x_q[k];
    end
    if (cur_lit == '0) begin
      acc_nxt = 1'b0;
      all_nxt = all_q & acc_q;
    end else begin
      acc_nxt = acc_q | cur_true;
      all_nxt = all_q;
    end
    all_fin = (cur_lit == '0) ? all_nxt : (all_nxt & acc_nxt);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= StIdle;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:  if (start_ok) state_d = StLoad;
      StLoad:  if (last_idx) state_d = StRun;
      StRun: begin
        if (sat.sat_done)  state_d = StCheck;
        else if (expired)  state_d = StIdle;
      end
      StCheck: if (last_idx) state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_comb begin
    busy_o     = !in_idle;
    wr_ready_o = in_idle && !rst && (count_q < DepthC);
    sat_load   = (state_q == StLoad);
    sat_run    = (state_q == StRun);
    sat_data   = sat_load ? cur_lit : '0;
  end

  assign sat.sat_data = sat_data;
  assign sat.sat_load = sat_load;
  assign sat.sat_run  = sat_run;

  always_ff @(posedge clk) begin
    if (wr_fire) lit_mem_q[count_q[AddrW-1:0]] <= wr_lit_i;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count_q     <= '0;
      idx_q       <= '0;
      tmr_q       <= '0;
      err_q       <= 1'b0;
      res_valid_q <= 1'b0;
      res_sat_q   <= 1'b0;
      res_x_q     <= '0;
      check_ok_q  <= 1'b0;
      timeout_q   <= 1'b0;
      acc_q       <= 1'b0;
      all_q       <= 1'b0;
    end else begin
      res_valid_q <= 1'b0;
      unique case (state_q)
        StIdle: begin
          if (clr_i) begin
            count_q <= '0;
            err_q   <= 1'b0;
          end else if (wr_fire) begin
            count_q <= count_q + CntW'(1);
          end
          if (wr_bad) err_q <= 1'b1;
          if (start_ok) begin
            idx_q      <= '0;
            res_sat_q  <= 1'b0;
            res_x_q    <= '0;
            check_ok_q <= 1'b0;
            timeout_q  <= 1'b0;
          end
        end
        StLoad: begin
          idx_q <= last_idx ? '0 : idx_q + CntW'(1);
          tmr_q <= '0;
        end
        StRun: begin
          tmr_q <= tmr_q + TmrW'(1);
          if (sat.sat_done) begin
            res_sat_q <= sat.sat_sol;
            res_x_q   <= sat.sat_x;
            acc_q     <= 1'b0;
            all_q     <= 1'b1;
          end else if (expired) begin
            timeout_q   <= 1'b1;
            res_sat_q   <= 1'b0;
            res_x_q     <= '0;
            res_valid_q <= 1'b1;
          end
        end
        StCheck: begin
          idx_q <= idx_q + CntW'(1);
          acc_q <= acc_nxt;
          all_q <= all_nxt;
          if (last_idx) begin
            check_ok_q  <= res_sat_q && all_fin;
            res_valid_q <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  assign err_o          = err_q;
  assign result_valid_o = res_valid_q;
  assign result_sat_o   = res_sat_q;
  assign result_x_o     = res_x_q;
  assign check_ok_o     = check_ok_q;
  assign timeout_o      = timeout_q;
endmodule

// File: tb/tb_tinysat_host.sv
// Bench for tinysat_host: timeline model of a solve checked every cycle, plus directed
// scenarios with hand-computed results and a small programmable solver responder.
module tb_tinysat_host;
  localparam int NV = 4;
  localparam int DP = 32;
  localparam int TO = 15;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          wr_valid = 1'b0;
  logic [4:0]    wr_lit = '0;
  logic          clr = 1'b0;
  logic          start = 1'b0;
  logic          wr_ready, busy, err, result_valid, result_sat, check_ok, timeout;
  logic [NV-1:0] result_x;

  tinysat_host_if #(.NVARS(NV)) sif ();

  tinysat_host #(.NVARS(NV), .DEPTH(DP), .TIMEOUT(TO)) dut (
    .clk            (clk),
    .rst            (rst),
    .wr_valid_i     (wr_valid),
    .wr_lit_i       (wr_lit),
    .wr_ready_o     (wr_ready),
    .clr_i          (clr),
    .start_i        (start),
    .busy_o         (busy),
    .err_o          (err),
    .result_valid_o (result_valid),
    .result_sat_o   (result_sat),
    .result_x_o     (result_x),
    .check_ok_o     (check_ok),
    .timeout_o      (timeout),
    .sat            (sif)
  );

  always #5 clk = ~clk;

  // Solver responder: raises done during RUN cycle number done_at (0-based).
  int            done_at = 1000;
  int            run_cnt = 0;
  logic [NV-1:0] sv_x = '0;
  logic          sv_sol = 1'b0;
  logic          sv_done = 1'b0;
  assign sif.sat_x    = sv_x;
  assign sif.sat_sol  = sv_sol;
  assign sif.sat_done = sv_done;

  always @(negedge clk) begin
    if (sif.sat_run) begin
      sv_done <= (run_cnt == done_at);
      run_cnt <= run_cnt + 1;
    end else begin
      sv_done <= 1'b0;
      run_cnt <= 0;
    end
  end

  int checks = 0;
  int failures = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Clause-by-clause CNF evaluation straight from the literal list.
  function automatic bit cnf_sat(input int lits[$], input logic [NV-1:0] x);
    bit all_ok = 1, has = 0, sat_c = 0;
    foreach (lits[i]) begin
      if (lits[i] == 0) begin
        if (!(has && sat_c)) all_ok = 0;
        has = 0;
        sat_c = 0;
      end else begin
        has = 1;
        if (lits[i] > 0 && x[lits[i]-1]) sat_c = 1;
        if (lits[i] < 0 && !x[-lits[i]-1]) sat_c = 1;
      end
    end
    if (has && !sat_c) all_ok = 0;
    return all_ok;
  endfunction

  // Model: buffer contents, sticky error, and the timeline of the solve in progress.
  int            m_buf[$];
  bit            m_err = 0, m_act = 0, m_donep = 0;
  int            m_r = 0, m_n = 0, m_rlen = 0;
  bit            fin_sat = 0, fin_ok = 0, fin_to = 0;
  logic [NV-1:0] fin_x = '0;
  bit            r_sat = 0, r_ok = 0, r_to = 0;
  logic [NV-1:0] r_x = '0;
  int            n_load = 0, n_run = 0;

  always @(negedge clk) begin : cmp
    int         total, v;
    bit         e_load, e_run, e_rv, take_start;
    logic [4:0] e_data;
    if (sif.sat_load) n_load++;
    if (sif.sat_run)  n_run++;
    if (rst) begin
      chk("rst_wr_ready", wr_ready, 0);
      chk("rst_busy", busy, 0);
      chk("rst_sat_load", sif.sat_load, 0);
      chk("rst_sat_run", sif.sat_run, 0);
      chk("rst_sat_data", sif.sat_data, 0);
      chk("rst_result_valid", result_valid, 0);
      chk("rst_err", err, 0);
      chk("rst_results", {result_sat, result_x, check_ok, timeout}, 0);
      m_buf.delete();
      m_err = 0; m_act = 0;
      r_sat = 0; r_x = '0; r_ok = 0; r_to = 0;
    end else begin
      total = m_n + m_rlen + (m_donep ? m_n : 0);
      e_rv = 0;
      if (m_act && m_r == total) begin
        m_act = 0; e_rv = 1;
        r_sat = fin_sat; r_x = fin_x; r_ok = fin_ok; r_to = fin_to;
      end
      e_load = m_act && (m_r < m_n);
      e_run  = m_act && (m_r >= m_n) && (m_r < m_n + m_rlen);
      e_data = e_load ? 5'(m_buf[m_r]) : 5'd0;
      chk("busy", busy, m_act);
      chk("wr_ready", wr_ready, !m_act && (m_buf.size() < DP));
      chk("sat_load", sif.sat_load, e_load);
      chk("sat_run", sif.sat_run, e_run);
      chk("sat_data", sif.sat_data, e_data);
      chk("result_valid", result_valid, e_rv);
      chk("err", err, m_err);
      if (!m_act || m_r < m_n) begin
        chk("result_sat", result_sat, r_sat);
        chk("result_x", result_x, r_x);
        chk("check_ok", check_ok, r_ok);
        chk("timeout", timeout, r_to);
      end
      if (m_act) begin
        m_r++;
      end else begin
        take_start = start && !clr && (m_buf.size() > 0);
        if (clr) begin
          m_buf.delete();
          m_err = 0;
        end else if (wr_valid && m_buf.size() < DP) begin
          v = int'($signed(wr_lit));
          if (v >= -NV && v <= NV) m_buf.push_back(v);
          else m_err = 1;
        end
        if (take_start) begin
          m_act = 1; m_r = 0; m_n = m_buf.size();
          r_sat = 0; r_x = '0; r_ok = 0; r_to = 0;
          if (done_at <= TO) begin
            m_donep = 1; m_rlen = done_at + 1;
            fin_sat = sv_sol; fin_x = sv_x; fin_to = 0;
            fin_ok = sv_sol && cnf_sat(m_buf, sv_x);
          end else begin
            m_donep = 0; m_rlen = TO + 1;
            fin_sat = 0; fin_x = '0; fin_ok = 0; fin_to = 1;
          end
        end
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input int l);
    wr_valid = 1'b1;
    wr_lit   = 5'(l);
    step();
    wr_valid = 1'b0;
  endtask

  task automatic pulse_start();
    start = 1'b1;
    step();
    start = 1'b0;
  endtask

  task automatic pulse_clr();
    clr = 1'b1;
    step();
    clr = 1'b0;
  endtask

  task automatic wait_result(input string nm);
    bit seen = 0;
    for (int i = 0; i < 300 && !seen; i++) begin
      @(negedge clk);
      if (result_valid) seen = 1;
    end
    checks++;
    if (!seen) begin
      failures++;
      $display("FAIL %s_result_valid actual=0 required=1 within 300 cycles", nm);
    end
  endtask

  int f1[6] = '{1, 2, 0, -1, 3, 0};
  int l0, r0;

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1);
  end

  initial begin
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    step();

    // Invalid literals are rejected and leave the buffer empty.
    wr(5);
    wr(-16);
    chk("t3_err", err, 1);
    chk("t3_wr_ready", wr_ready, 1);
    pulse_start();
    chk("t3_start_ignored", busy, 0);
    pulse_clr();
    chk("t3_err_cleared", err, 0);

    // Correct assignment from the solver.
    foreach (f1[i]) wr(f1[i]);
    done_at = 3; sv_sol = 1'b1; sv_x = 4'b0010;
    l0 = n_load; r0 = n_run;
    pulse_start();
    wait_result("t1");
    chk("t1_load_cycles", n_load - l0, 6);
    chk("t1_run_cycles", n_run - r0, 4);
    chk("t1_result_sat", result_sat, 1);
    chk("t1_result_x", result_x, 4'b0010);
    chk("t1_check_ok", check_ok, 1);
    chk("t1_timeout", timeout, 0);

    // Wrong assignment: clause (1 | 2) fails under x=0000.
    step();
    sv_x = 4'b0000;
    pulse_start();
    chk("t2_results_cleared", result_sat, 0);
    chk("t2_busy", busy, 1);
    wait_result("t2");
    chk("t2_result_sat", result_sat, 1);
    chk("t2_check_ok", check_ok, 0);

    // Full buffer: 32 literals accepted, the 33rd dropped.
    step();
    pulse_clr();
    for (int i = 0; i < DP; i++) wr((i % 9) - 4);
    chk("t4_wr_ready_full", wr_ready, 0);
    wr(1);
    chk("t4_err", err, 0);
    done_at = 0; sv_sol = 1'b1; sv_x = 4'b1111;
    l0 = n_load;
    pulse_start();
    wait_result("t4");
    chk("t4_load_cycles", n_load - l0, 32);

    // Solver never answers: timeout after TO+1 run cycles.
    step();
    pulse_clr();
    wr(1);
    wr(0);
    done_at = 1000;
    r0 = n_run;
    pulse_start();
    wait_result("t5");
    chk("t5_run_cycles", n_run - r0, 16);
    chk("t5_timeout", timeout, 1);
    chk("t5_result_sat", result_sat, 0);
    chk("t5_result_x", result_x, 0);

    // Reset in the middle of LOAD.
    step();
    pulse_clr();
    foreach (f1[i]) wr(f1[i]);
    done_at = 3;
    pulse_start();
    step();
    step();
    step();
    chk("t6_load_lit3", sif.sat_load, 1);
    chk("t6_data_lit3", sif.sat_data, 5'h1f);
    rst = 1'b1;
    #1;
    chk("t6_load_dropped", sif.sat_load, 0);
    chk("t6_run_dropped", sif.sat_run, 0);
    chk("t6_busy_dropped", busy, 0);
    step();
    rst = 1'b0;
    #1;
    chk("t6_wr_ready", wr_ready, 1);
    step();
    pulse_start();
    chk("t6_start_ignored", busy, 0);
    step();
    step();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
